// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-memory access stage.
// Size codes, FSM states and the alignment check.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == SZ_ILL)
      || (size == SZ_HALF && lo[0])
      || (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication
// and load lane extraction with extension.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  wen,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  ld_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ldata
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign b_sel = rdata[{ld_lo, 3'b000} +: 8];
  assign h_sel = rdata[{ld_lo[1], 4'b0000} +: 16];

  // Store side: byte enables and lane replication
  always_comb begin
    wen   = 4'b0000;
    wdata = st_data;
    unique case (1'b1)
      st_size == SZ_BYTE: begin
        wen   = 4'b0001 << st_lo;
        wdata = {4{st_data[7:0]}};
      end
      st_size == SZ_HALF: begin
        wen   = st_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      st_size == SZ_WORD: begin
        wen   = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load side: lane select then sign/zero extend
  always_comb begin
    ldata = 32'd0;
    unique case (1'b1)
      ld_size == SZ_BYTE:
        ldata = {{24{ld_signed & b_sel[7]}}, b_sel};
      ld_size == SZ_HALF:
        ldata = {{16{ld_signed & h_sel[15]}}, h_sel};
      ld_size == SZ_WORD:
        ldata = rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: turns sized loads/stores
// into word SRAM transactions and stalls until done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        addr_err,
  output logic        timeout_err,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_WAIT - 1);

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lat_size;
  logic             lat_signed;
  logic [1:0]       lat_lo;
  logic             lat_write;
  logic             bad;
  logic             expired;
  logic [3:0]       st_wen;
  logic [31:0]      st_wdata;
  logic [31:0]      ld_data;

  assign bad     = misaligned(req_size, req_addr[1:0]);
  assign expired = (cnt == CNT_LAST);
  assign stall   = req_valid & ~done;

  mem_lane_align u_align (
    .st_size   (req_size),
    .st_lo     (req_addr[1:0]),
    .st_data   (req_wdata),
    .wen       (st_wen),
    .wdata     (st_wdata),
    .ld_size   (lat_size),
    .ld_signed (lat_signed),
    .ld_lo     (lat_lo),
    .rdata     (sram_rdata),
    .ldata     (ld_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (req_valid)
          state_nx = bad ? S_DONE : S_WAIT;
      S_WAIT:
        if (sram_ready || expired)
          state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  // Registered outputs, request latch and wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      lat_size    <= 2'd0;
      lat_signed  <= 1'b0;
      lat_lo      <= 2'd0;
      lat_write   <= 1'b0;
      done        <= 1'b0;
      addr_err    <= 1'b0;
      timeout_err <= 1'b0;
      rdata_out   <= 32'd0;
      sram_en     <= 1'b0;
      sram_wen    <= 4'd0;
      sram_addr   <= 32'd0;
      sram_wdata  <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (bad) begin
              addr_err <= 1'b1;
              done     <= 1'b1;
            end else begin
              sram_en    <= 1'b1;
              sram_addr  <= {req_addr[31:2], 2'b00};
              sram_wen   <= req_write ? st_wen : 4'd0;
              sram_wdata <= st_wdata;
              lat_size   <= req_size;
              lat_signed <= req_signed;
              lat_lo     <= req_addr[1:0];
              lat_write  <= req_write;
              cnt        <= '0;
            end
          end
        end
        S_WAIT: begin
          sram_en <= 1'b0;
          if (sram_ready) begin
            if (!lat_write) rdata_out <= ld_data;
            done <= 1'b1;
          end else if (expired) begin
            if (!lat_write) rdata_out <= 32'd0;
            timeout_err <= 1'b1;
            done        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done        <= 1'b0;
          addr_err    <= 1'b0;
          timeout_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Data-memory access stage between the CPU's MEM-stage outputs (address, store data, store flag) and a variable-latency data SRAM.
- Converts size-qualified loads/stores into byte-enabled, word-aligned SRAM transactions.
- Stalls the pipeline until the SRAM responds, then returns aligned, sign- or zero-extended load data.
- Flags misaligned addresses and SRAM timeouts.

Parameters:
- MAX_WAIT, 16: cycles allowed in WAIT before a timeout is declared (≥2).
- CNT_W, 5: width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  MEM-stage access request; held until done
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_signed  in  1  load sign-extend enable
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  req_valid & ~done, combinational
- done  out  1  one-cycle completion pulse
- rdata_out  out  32  extended load result, held until next load completes
- addr_err  out  1  pulse with done on a misaligned or illegal access
- timeout_err  out  1  pulse with done when the SRAM does not respond
- sram_en  out  1  one-cycle request strobe
- sram_wen  out  4  byte write enables; 0 for loads
- sram_addr  out  32  {req_addr[31:2],2'b00}
- sram_wdata  out  32  lane-replicated store data
- sram_rdata  in  32  read data, valid with sram_ready
- sram_ready  in  1  response valid; sampled only in WAIT

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0. All outputs 0, including rdata_out. Any in-flight transaction is dropped; a late sram_ready is ignored.
- States: IDLE, WAIT, DONE. All outputs except stall are registered.
- IDLE, req_valid=1, aligned:
  - Register sram_addr, sram_wen, sram_wdata.
  - Latch size, signed and addr[1:0] for extension.
  - sram_en<=1, cnt<=0, go WAIT.
- IDLE, req_valid=1, misaligned (half with addr[0]=1; word with addr[1:0]≠0; size=3):
  - No SRAM access.
  - addr_err<=1, done<=1, go DONE. rdata_out unchanged.
- WAIT:
  - sram_en<=0 after the first WAIT cycle, so the strobe is exactly one cycle.
  - sram_ready=1: if load, rdata_out<=extended data; done<=1; go DONE. Stores complete identically and do not alter rdata_out.
  - sram_ready=0 and cnt==MAX_WAIT-1: timeout_err<=1, done<=1, rdata_out<=0 for a load, go DONE.
  - Otherwise cnt<=cnt+1.
- DONE: done, addr_err, timeout_err<=0; go IDLE. req_valid is ignored this cycle, which prevents re-issue of the retiring request.
- Latency: req_valid at cycle 0 → sram_en at cycle 1. sram_ready sampled at cycle k≥1 → done at cycle k+1. Minimum latency is 2 cycles.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- Store data: byte replicated ×4, half replicated ×2.
- Load extension:
  - Select lane sram_rdata[8*a+:8] (byte) or [16*addr[1]+:16] (half).
  - Sign-extend if the latched signed flag is 1, else zero-extend. Word is passed through.
- req_* changes while in WAIT are ignored; the latched values are used.
- sram_ready in IDLE or DONE is ignored.

Decomposition:
- Shared package holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD
  - state encodings S_IDLE/S_WAIT/S_DONE
- Natural sub-module: mem_lane_align. It is combinational and does byte-enable generation, store replication and load extraction/extension. It is instantiated once, and its load half is reused on sram_rdata.

Test Plan:
- Load word, addr 0x100, SRAM ready 3 cycles after sram_en, rdata 0xDEADBEEF → sram_addr 0x100, wen 0; done 4 cycles after sram_en; rdata_out 0xDEADBEEF; stall high until done.
- Signed byte load, addr 0x103, rdata 0x80FF_1234 → rdata_out 0xFFFFFF80; same access unsigned → 0x00000080.
- Store half 0xABCD at addr 0x202 → sram_wen 4'b1100, sram_wdata 0xABCDABCD, sram_addr 0x200; rdata_out unchanged.
- Load word at addr 0x101 → no sram_en; addr_err and done pulse one cycle after request.
- Load word with sram_ready never asserted → timeout_err and done after MAX_WAIT WAIT cycles; rdata_out 0; a later stray sram_ready is ignored.
- rst asserted low mid-WAIT → all outputs 0 immediately; after release, a new request completes normally with minimum 2-cycle latency.
